// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads 1-3 byte 6502/2A03 instructions at {pc_h,pc_l}, pulses pc_inc once per
// accepted byte, and hands each assembled bundle to the decoder.
module instr_fetch #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        pc_l,
  input  logic [7:0]        pc_h,
  output logic              pc_inc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_valid,
  input  logic              flush,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_opcode,
  output logic [DATA_W-1:0] ir_op_lo,
  output logic [DATA_W-1:0] ir_op_hi,
  output logic [1:0]        ir_len,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              fetch_err,
  output logic [1:0]        dbg_state
);

  // Handshake: the bundle transfers on a cycle where ir_valid && ir_ready. While ir_valid is high,
  // the bundle holds steady until that transfer or a flush. ir_ready is ignored while ir_valid is low.
  typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;
  typedef enum logic [1:0] {SLOT_OP = 2'd0, SLOT_LO = 2'd1, SLOT_HI = 2'd2} slot_t;

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  state_t            state;
  slot_t             slot;
  logic              drop;
  logic [CW-1:0]     wait_cnt;
  logic [ADDR_W-1:0] pc_now;
  logic [1:0]        rd_len;

  function automatic logic [1:0] instr_len(input logic [DATA_W-1:0] op);
    logic [3:0] hi_n;
    logic [3:0] lo_n;
    hi_n = op[7:4];
    lo_n = op[3:0];
    if (op == 8'h00 || op == 8'h40 || op == 8'h60) return 2'd1;
    if (op == 8'h20)                               return 2'd3;
    if (lo_n == 4'h8 || lo_n == 4'hA)              return 2'd1;
    if (lo_n >= 4'hC)                              return 2'd3;
    if ((lo_n == 4'h9 || lo_n == 4'hB) && hi_n[0]) return 2'd3;
    return 2'd2;
  endfunction

  assign pc_now    = ADDR_W'({pc_h, pc_l});
  assign rd_len    = instr_len(mem_rd_data);
  // A pending stale response (drop) blocks new requests; the flush cycle itself never issues one
  // because the PC is being reloaded then.
  assign mem_rd_en = rst_n && !flush && !drop && (state == S_REQ);
  assign mem_addr  = mem_rd_en ? pc_now : '0;
  assign pc_inc    = rst_n && !flush && (state == S_WAIT) && mem_rd_valid;
  assign ir_valid  = (state == S_HOLD);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_REQ;
      slot      <= SLOT_OP;
      drop      <= 1'b0;
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
      ir_opcode <= '0;
      ir_op_lo  <= '0;
      ir_op_hi  <= '0;
      ir_len    <= '0;
      ir_pc     <= '0;
    end else if (flush) begin
      state     <= S_REQ;
      slot      <= SLOT_OP;
      wait_cnt  <= '0;
      drop      <= (drop || state == S_WAIT) && !mem_rd_valid;
      ir_opcode <= '0;
      ir_op_lo  <= '0;
      ir_op_hi  <= '0;
      ir_len    <= '0;
      ir_pc     <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (drop) begin
            if (mem_rd_valid) drop <= 1'b0;
          end else begin
            state    <= S_WAIT;
            wait_cnt <= '0;
            if (slot == SLOT_OP) ir_pc <= pc_now;
          end
        end
        S_WAIT: begin
          if (mem_rd_valid) begin
            wait_cnt <= '0;
            case (slot)
              SLOT_OP: begin
                ir_opcode <= mem_rd_data;
                ir_len    <= rd_len;
                if (rd_len == 2'd1) begin
                  state <= S_HOLD;
                end else begin
                  slot  <= SLOT_LO;
                  state <= S_REQ;
                end
              end
              SLOT_LO: begin
                ir_op_lo <= mem_rd_data;
                if (ir_len == 2'd2) begin
                  state <= S_HOLD;
                end else begin
                  slot  <= SLOT_HI;
                  state <= S_REQ;
                end
              end
              default: begin
                ir_op_hi <= mem_rd_data;
                state    <= S_HOLD;
              end
            endcase
          end else begin
            // Watchdog only raises the sticky error; the fetch keeps waiting for its response.
            if (wait_cnt != CW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
            if (MAX_WAIT != 0 && wait_cnt == CW'(MAX_WAIT - 1)) fetch_err <= 1'b1;
          end
        end
        S_HOLD: begin
          if (ir_ready) begin
            state     <= S_REQ;
            slot      <= SLOT_OP;
            ir_opcode <= '0;
            ir_op_lo  <= '0;
            ir_op_hi  <= '0;
            ir_len    <= '0;
            ir_pc     <= '0;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: PC register and memory models drive the DUT. A scoreboard holds the expected
// bundles, which come from a byte-level program model. A second instance covers the watchdog.
module tb_instr_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [15:0] pc = 16'h0000;
  logic        pc_inc, mem_rd_en, mem_rd_valid = 1'b0, flush = 1'b0, ir_valid, ir_ready = 1'b0, fetch_err;
  logic [15:0] mem_addr, ir_pc;
  logic [7:0]  mem_rd_data = 8'h00, ir_opcode, ir_op_lo, ir_op_hi;
  logic [1:0]  ir_len, dbg_state;

  logic        rst_w_n = 1'b0;
  logic [7:0]  pc_l_w = 8'h00, pc_h_w = 8'h12, rd_data_w = 8'h00;
  logic        rd_valid_w = 1'b0, flush_w = 1'b0, ready_w = 1'b0;
  logic        pc_inc_w, rd_en_w, ir_valid_w, fetch_err_w;
  logic [15:0] mem_addr_w, ir_pc_w;
  logic [7:0]  opcode_w, op_lo_w, op_hi_w;
  logic [1:0]  ir_len_w, dbg_state_w;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .pc_l(pc[7:0]), .pc_h(pc[15:8]), .pc_inc(pc_inc),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid), .flush(flush), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir_opcode(ir_opcode), .ir_op_lo(ir_op_lo), .ir_op_hi(ir_op_hi), .ir_len(ir_len),
    .ir_pc(ir_pc), .fetch_err(fetch_err), .dbg_state(dbg_state));

  instr_fetch #(.MAX_WAIT(4)) dut_wd (
    .clk(clk), .rst_n(rst_w_n), .pc_l(pc_l_w), .pc_h(pc_h_w), .pc_inc(pc_inc_w),
    .mem_addr(mem_addr_w), .mem_rd_en(rd_en_w), .mem_rd_data(rd_data_w),
    .mem_rd_valid(rd_valid_w), .flush(flush_w), .ir_valid(ir_valid_w), .ir_ready(ready_w),
    .ir_opcode(opcode_w), .ir_op_lo(op_lo_w), .ir_op_hi(op_hi_w), .ir_len(ir_len_w),
    .ir_pc(ir_pc_w), .fetch_err(fetch_err_w), .dbg_state(dbg_state_w));

  logic [7:0]  mem [0:65535];
  logic [41:0] exp_q[$];
  logic [41:0] e;
  logic [15:0] rd_log[$];
  logic [15:0] start_pc = 16'h0000, flush_pc = 16'h0000;
  int errors = 0, checks = 0, cyc = 0, hs_cnt = 0, cnt_inc = 0, cnt_rd = 0;
  int first_rd = -1, first_vld = -1, fixed_lat = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_len(input logic [7:0] op);
    int h, l;
    h = int'(op[7:4]);
    l = int'(op[3:0]);
    if (op == 8'h00 || op == 8'h40 || op == 8'h60) return 2'd1;
    if (op == 8'h20) return 2'd3;
    if (l == 8 || l == 10) return 2'd1;
    if (l >= 12) return 2'd3;
    if ((l == 9 || l == 11) && (h % 2 == 1)) return 2'd3;
    return 2'd2;
  endfunction

  // Expected bundle {pc, len, hi, lo, op} for an instruction starting at address a.
  function automatic logic [41:0] model(input logic [15:0] a);
    logic [15:0] a1, a2;
    logic [7:0]  op, lo, hi;
    logic [1:0]  n;
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    op = mem[a];
    n  = ref_len(op);
    lo = (n >= 2'd2) ? mem[a1] : 8'h00;
    hi = (n == 2'd3) ? mem[a2] : 8'h00;
    return {a, n, hi, lo, op};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // PC register model: reload on flush, otherwise increment on pc_inc.
  initial begin
    logic c_rst, c_fl, c_inc;
    logic [15:0] c_fpc;
    forever begin
      @(negedge clk);
      c_rst = rst_n; c_fl = flush; c_inc = pc_inc; c_fpc = flush_pc;
      @(posedge clk);
      #1;
      if (!c_rst)     pc = start_pc;
      else if (c_fl)  pc = c_fpc;
      else if (c_inc) pc = pc + 16'd1;
    end
  end

  // Memory responder: one response per request; a request while one is pending is an error.
  initial begin
    logic [15:0] a;
    int lat;
    forever begin
      @(negedge clk);
      if (rst_n && mem_rd_en) begin
        a = mem_addr;
        chk("rd_addr", a, pc);
        rd_log.push_back(a);
        lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
        @(posedge clk); #1;
        for (int k = 0; k < lat; k++) begin
          @(negedge clk);
          if (mem_rd_en) chk("rd_overlap", 1, 0);
          @(posedge clk); #1;
        end
        mem_rd_valid = 1'b1;
        mem_rd_data  = mem[a];
        @(negedge clk);
        if (mem_rd_en) chk("rd_overlap", 1, 0);
        @(posedge clk); #1;
        mem_rd_valid = 1'b0;
      end
    end
  end

  // Monitor: compares each handshaken bundle against the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      exp_q.push_back(model(start_pc));
      hs_cnt = 0; cnt_inc = 0; cnt_rd = 0; first_rd = -1; first_vld = -1;
    end else begin
      if (pc_inc) cnt_inc++;
      if (mem_rd_en) begin
        cnt_rd++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (ir_valid && first_vld < 0) first_vld = cyc;
      if (ir_valid && ir_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bundle: got %0h expected none", {ir_pc, ir_len, ir_op_hi, ir_op_lo, ir_opcode});
        end else begin
          e = exp_q.pop_front();
          chk("bundle", {ir_pc, ir_len, ir_op_hi, ir_op_lo, ir_opcode}, e);
          if (!flush) exp_q.push_back(model(e[41:26] + {14'd0, e[25:24]}));
        end
      end
      if (flush) begin
        exp_q.delete();
        exp_q.push_back(model(flush_pc));
      end
    end
  end

  task automatic do_reset(input logic [15:0] sp);
    start_pc = sp; ir_ready = 1'b0; flush = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", dbg_state, 0);
    chk("rst_outputs", {mem_rd_en, pc_inc, ir_valid, fetch_err, mem_addr, ir_len, ir_pc, ir_opcode}, 0);
    rd_log.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n = 0;
    while (hs_cnt < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (hs_cnt < target) begin
      errors++;
      $display("FAIL hs_timeout: got %0d handshakes expected %0d", hs_cnt, target);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    ir_ready = 1'b0;
    while (!ir_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_valid", ir_valid, 1);
  endtask

  task automatic chk_reads(input int n, input logic [15:0] a0, a1, a2, a3);
    logic [15:0] ex [4];
    ex = '{a0, a1, a2, a3};
    chk("rd_count", rd_log.size(), n);
    for (int k = 0; k < n && k < rd_log.size(); k++) chk("rd_seq", rd_log[k], ex[k]);
  endtask

  initial begin
    int snap_rd, snap_inc;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    // 1-byte instruction with 1-cycle memory; T4 hold-stability continues from here.
    mem[16'h8000] = 8'hEA; mem[16'h8001] = 8'hEA; mem[16'h8002] = 8'hEA;
    fixed_lat = 0;
    do_reset(16'h8000);
    ir_ready = 1'b1;
    wait_hs(1, 40);
    wait_idle();
    chk("latency", 64'(first_vld - first_rd), 2);
    chk("t1_inc", cnt_inc, 2);
    chk_reads(2, 16'h8000, 16'h8001, 16'h0, 16'h0);
    snap_rd = cnt_rd; snap_inc = cnt_inc;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_bundle", {ir_valid, ir_opcode, ir_len, ir_pc}, {1'b1, 8'hEA, 2'd1, 16'h8001});
      @(posedge clk); #1;
    end
    chk("hold_no_rd", cnt_rd, snap_rd);
    chk("hold_no_inc", cnt_inc, snap_inc);
    ir_ready = 1'b1;
    wait_hs(2, 40);
    wait_idle();

    // 2-byte instruction.
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42; mem[16'h8002] = 8'hEA;
    do_reset(16'h8000);
    ir_ready = 1'b1;
    wait_hs(1, 40);
    wait_idle();
    chk("t2_inc", cnt_inc, 3);
    chk_reads(3, 16'h8000, 16'h8001, 16'h8002, 16'h0);

    // 3-byte instruction across the address wrap.
    mem[16'hFFFE] = 8'h4C; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12; mem[16'h0001] = 8'hEA;
    do_reset(16'hFFFE);
    ir_ready = 1'b1;
    wait_hs(1, 40);
    wait_idle();
    chk("t3_inc", cnt_inc, 4);
    chk_reads(4, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001);

    // Flush while waiting for the operand byte; the late response must be dropped.
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h55; mem[16'h9000] = 8'hEA; mem[16'h9001] = 8'hEA;
    fixed_lat = 3;
    do_reset(16'h8000);
    ir_ready = 1'b1;
    for (int n = 0; n < 40 && rd_log.size() < 2; n++) begin
      @(posedge clk); #1;
    end
    chk("t5_second_rd", rd_log.size(), 2);
    flush = 1'b1; flush_pc = 16'h9000;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_hs(1, 60);
    wait_idle();
    chk("t5_inc", cnt_inc, 3);
    chk_reads(4, 16'h8000, 16'h8001, 16'h9000, 16'h9001);

    // Randomized traffic: random ready, memory latency and flush targets.
    fixed_lat = -1;
    do_reset(16'($urandom));
    for (int i = 0; i < 3000; i++) begin
      ir_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 24) == 0) begin
        flush = 1'b1;
        flush_pc = 16'($urandom);
      end else begin
        flush = 1'b0;
      end
      @(posedge clk); #1;
    end
    flush = 1'b0;
    ir_ready = 1'b1;
    wait_hs(hs_cnt + 3, 200);
    wait_idle();
    chk("no_fetch_err", fetch_err, 0);
    chk("rand_activity", 64'(hs_cnt > 100), 1);

    // Watchdog: memory never answers.
    rst_w_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_w_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("wd_before", fetch_err_w, 0);
    @(posedge clk);
    @(negedge clk);
    chk("wd_set", fetch_err_w, 1);
    chk("wd_still_wait", dbg_state_w, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("wd_sticky", fetch_err_w, 1);
    @(posedge clk); #1;
    rst_w_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("wd_rst_clear", fetch_err_w, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

endmodule
